// File: rtl/key_filter.sv
// Debounces KEY_NUM active-low buttons: 2-FF sync, then a per-key 4-state filter FSM with a CNT_20MS+1 cycle window.
// Optional macro KEY_RELEASE_EN adds the key_release pulse output.
module key_filter #(
  parameter int KEY_NUM  = 4,
  parameter int CNT_20MS = 999_999,
  parameter int CNT_W    = 20
) (
  input  logic               sclk,
  input  logic               s_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_press,
`ifdef KEY_RELEASE_EN
  output logic [KEY_NUM-1:0] key_release,
`endif
  output logic [KEY_NUM-1:0] key_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_20MS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLT_DN = 2'd1,
    DOWN   = 2'd2,
    FLT_UP = 2'd3
  } state_t;

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] ks;

  // Idle-high reset value so a released key never looks like a press.
  always_ff @(posedge sclk or negedge s_rst) begin
    if (!s_rst) begin
      sync1 <= '1;
      ks    <= '1;
    end else begin
      sync1 <= key_in;
      ks    <= sync1;
    end
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             level;
    logic             release_p;

    always_ff @(posedge sclk or negedge s_rst) begin
      if (!s_rst) begin
        state     <= IDLE;
        cnt       <= '0;
        press     <= 1'b0;
        level     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_p <= 1'b0;
        case (state)
          IDLE: begin
            if (!ks[i]) begin
              state <= FLT_DN;
              cnt   <= '0;
            end
          end
          FLT_DN: begin
            if (ks[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state <= DOWN;
              cnt   <= '0;
              press <= 1'b1;
              level <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DOWN: begin
            if (ks[i]) begin
              state <= FLT_UP;
              cnt   <= '0;
            end
          end
          FLT_UP: begin
            // A bounce back to pressed resumes the held state without a new pulse.
            if (!ks[i]) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state     <= IDLE;
              cnt       <= '0;
              level     <= 1'b0;
              release_p <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_press[i] = press;
    assign key_level[i] = level;
`ifdef KEY_RELEASE_EN
    assign key_release[i] = release_p;
`else
    logic unused_release;
    assign unused_release = release_p;
`endif
  end

endmodule
